mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit with its own HI/LO register pair, for the EX stage.
- Replaces the separate mul/div instances and the EX-local div stall logic.
- Adds several features:
  - a start/busy/done handshake;
  - annul (cancel);
  - multiply-accumulate and multiply-subtract ops;
  - MTHI/MTLO write ports;
  - a defined divide-by-zero result.
- EX pulses start, stalls on stallreq, and reads hi_o/lo_o for MFHI/MFLO.

---
 rtl/mdu_iter_if.sv | 31 +++
 rtl/mdu_iter.sv | 180 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// Handshake and data bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage drives through the master modport; the unit sits on the slave modport.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             annul;
  logic             hi_we;
  logic [WIDTH-1:0] hi_wdata;
  logic             lo_we;
  logic [WIDTH-1:0] lo_wdata;
  logic             busy;
  logic             stallreq;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start, op, src_a, src_b, annul, hi_we, hi_wdata, lo_we, lo_wdata,
    input  busy, stallreq, done, div_zero, hi_o, lo_o
  );

  modport slave (
    input  start, op, src_a, src_b, annul, hi_we, hi_wdata, lo_we, lo_wdata,
    output busy, stallreq, done, div_zero, hi_o, lo_o
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with its own HI/LO pair for the EX stage.
// Operands are reduced to magnitudes up front; FIX restores signs and accumulates.
module mdu_iter #(
  parameter int WIDTH  = 32,
  parameter bit EN_ACC = 1'b1
) (
  input logic       clk,
  input logic       rst,
  mdu_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t           state_r, state_nxt_s;
  logic [2:0]       op_s, op_r;
  logic             is_signed_s, is_div_s, b_zero_s, accept_s, busy_s;
  logic             sa_r, sb_r, dz_r;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, a_r, b_r;
  logic [PW-1:0]    prod_r, step_nxt_s, prod_sgn_s, res_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH+1:0] div_trial_s;
  logic [WIDTH-1:0] quo_s, rem_s, dividend_s;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r, div_zero_r;

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
    cond_neg = neg ? -v : v;
  endfunction

  // Operation decode; without the accumulate ops, MADD/MSUB fall back to MULT/MULTU.
  always_comb begin
    op_s = bus.op;
    if (!EN_ACC && bus.op[2]) begin
      op_s = {2'b00, bus.op[0]};
    end else begin
      op_s = bus.op;
    end
    is_signed_s = ~op_s[0];
    is_div_s    = (op_s[2:1] == 2'b01);
    b_zero_s    = (bus.src_b == {WIDTH{1'b0}});
    accept_s    = (state_r == IDLE) && bus.start && !bus.annul;
    a_mag_s     = cond_neg(is_signed_s && bus.src_a[WIDTH-1], bus.src_a);
    b_mag_s     = cond_neg(is_signed_s && bus.src_b[WIDTH-1], bus.src_b);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = (is_div_s && b_zero_s) ? FIX : CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (bus.annul) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == CW'(WIDTH - 1)) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum_s   = {1'b0, prod_r[PW-1:WIDTH]} + (prod_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    div_trial_s = {1'b0, prod_r[PW-1:WIDTH-1]} - {2'b00, b_r};
    step_nxt_s  = {mul_sum_s, prod_r[WIDTH-1:1]};
    if (op_r[2:1] == 2'b01) begin
      if (!div_trial_s[WIDTH+1]) begin
        step_nxt_s = {div_trial_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b1};
      end else begin
        step_nxt_s = {prod_r[PW-2:WIDTH-1], prod_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_nxt_s = {mul_sum_s, prod_r[WIDTH-1:1]};
    end
  end

  // Sign correction and accumulation applied in FIX; sa_r/sb_r are zero for unsigned ops.
  always_comb begin
    prod_sgn_s = (sa_r ^ sb_r) ? -prod_r : prod_r;
    quo_s      = cond_neg(sa_r ^ sb_r, prod_r[WIDTH-1:0]);
    rem_s      = cond_neg(sa_r, prod_r[PW-1:WIDTH]);
    dividend_s = cond_neg(sa_r, a_r);
    case (op_r)
      3'b010, 3'b011: res_s = dz_r ? {dividend_s, {WIDTH{1'b1}}} : {rem_s, quo_s};
      3'b100, 3'b101: res_s = {hi_r, lo_r} + prod_sgn_s;
      3'b110, 3'b111: res_s = {hi_r, lo_r} - prod_sgn_s;
      default:        res_s = prod_sgn_s;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r   <= 3'b000;
      sa_r   <= 1'b0;
      sb_r   <= 1'b0;
      dz_r   <= 1'b0;
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      prod_r <= {PW{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r   <= op_s;
            sa_r   <= is_signed_s & bus.src_a[WIDTH-1];
            sb_r   <= is_signed_s & bus.src_b[WIDTH-1];
            dz_r   <= is_div_s & b_zero_s;
            a_r    <= a_mag_s;
            b_r    <= b_mag_s;
            prod_r <= {{WIDTH{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
            cnt_r  <= {CW{1'b0}};
          end
        end
        CALC: begin
          prod_r <= step_nxt_s;
          cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        default: begin
        end
      endcase
    end
  end

  // HI/LO and completion flags; a FIX commit overrides a coincident MTHI/MTLO write.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      if (bus.hi_we) begin
        hi_r <= bus.hi_wdata;
      end
      if (bus.lo_we) begin
        lo_r <= bus.lo_wdata;
      end
      if ((state_r == FIX) && !bus.annul) begin
        hi_r       <= res_s[PW-1:WIDTH];
        lo_r       <= res_s[WIDTH-1:0];
        done_r     <= 1'b1;
        div_zero_r <= dz_r;
      end
    end
  end

  assign busy_s       = (state_r != IDLE);
  assign bus.busy     = busy_s;
  assign bus.stallreq = busy_s | (bus.start & ~bus.annul);
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi_o     = hi_r;
  assign bus.lo_o     = lo_r;
endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: a 32-bit accumulate-capable instance and an 8-bit EN_ACC=0 one.
module tb_mdu_iter;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(32)) bus32 ();
  mdu_iter_if #(.WIDTH(8))  bus8 ();

  mdu_iter #(.WIDTH(32), .EN_ACC(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  mdu_iter #(.WIDTH(8),  .EN_ACC(1'b0)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

  exp_t        q32[$];
  exp_t        q8[$];
  exp_t        mon32_e, mon8_e;
  logic [31:0] m_hi, m_lo;
  int          n_chk, n_pass;
  int          nb, ns;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi, input logic [31:0] lo);
    exp_t        e;
    longint      sa_l, sb_l;
    logic [63:0] p, q, r, acc, sp, up;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    acc  = {hi, lo};
    sp   = sa_l * sb_l;
    up   = {32'd0, a} * {32'd0, b};
    e.dz = (op[2:1] == 2'b01) && (b == 32'd0);
    case (op)
      3'b000: p = sp;
      3'b001: p = up;
      3'b010: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa_l / sb_l;
          r = sa_l % sb_l;
          p = {r[31:0], q[31:0]};
        end
      end
      3'b011: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      3'b100: p = acc + sp;
      3'b101: p = acc + up;
      3'b110: p = acc - sp;
      default: p = acc - up;
    endcase
    e.hi = p[63:32];
    e.lo = p[31:0];
    return e;
  endfunction

  task automatic exp32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model32(op, a, b, m_hi, m_lo);
    q32.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic exp_raw32(input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz;
    q32.push_back(e);
    m_hi = hi;
    m_lo = lo;
  endtask

  task automatic exp_raw8(input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = 1'b0;
    q8.push_back(e);
  endtask

  task automatic mt32(input logic [31:0] hi, input logic [31:0] lo);
    bus32.hi_we = 1'b1; bus32.hi_wdata = hi;
    bus32.lo_we = 1'b1; bus32.lo_wdata = lo;
    tick();
    bus32.hi_we = 1'b0;
    bus32.lo_we = 1'b0;
    m_hi = hi;
    m_lo = lo;
  endtask

  // Issues one op on the 32-bit unit, optionally pulses MTHI/MTLO in cycle wr_cyc, waits for done.
  task automatic do_op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input string tag, input int wr_cyc,
                         input logic [31:0] wr_hi, input logic [31:0] wr_lo,
                         output int n_busy, output int n_stall);
    int cyc;
    bus32.op = op; bus32.src_a = a; bus32.src_b = b; bus32.start = 1'b1;
    cyc = 0; n_busy = 0; n_stall = 0;
    #1;
    while (cyc < 60) begin
      if (bus32.busy) n_busy++;
      if (bus32.stallreq) n_stall++;
      if (cyc > 0 && bus32.done) break;
      @(posedge clk);
      #1;
      cyc++;
      bus32.start    = 1'b0;
      bus32.hi_we    = (cyc == wr_cyc);
      bus32.lo_we    = (cyc == wr_cyc);
      bus32.hi_wdata = wr_hi;
      bus32.lo_wdata = wr_lo;
      #1;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
  endtask

  // Issues one op on the 8-bit unit; a second start with other operands is pulsed in cycle ign_cyc.
  task automatic do_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input string tag, input int ign_cyc);
    int cyc;
    bus8.op = op; bus8.src_a = a; bus8.src_b = b; bus8.start = 1'b1;
    cyc = 0;
    #1;
    while (cyc < 40) begin
      if (cyc > 0 && bus8.done) break;
      @(posedge clk);
      #1;
      cyc++;
      bus8.start = (cyc == ign_cyc);
      if (cyc == ign_cyc) begin
        bus8.op = 3'b001; bus8.src_a = 8'd5; bus8.src_b = 8'd5;
      end
      #1;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
  endtask

  // 32-bit scoreboard: every done pops one expected result.
  always @(posedge clk) begin
    #1;
    if (bus32.done) begin
      chk("q32_pending", 64'(q32.size() > 0), 64'd1);
      if (q32.size() > 0) begin
        mon32_e = q32.pop_front();
        chk("hi32", 64'(bus32.hi_o), 64'(mon32_e.hi));
        chk("lo32", 64'(bus32.lo_o), 64'(mon32_e.lo));
        chk("dz32", 64'(bus32.div_zero), 64'(mon32_e.dz));
      end
    end
  end

  // 8-bit scoreboard.
  always @(posedge clk) begin
    #1;
    if (bus8.done) begin
      chk("q8_pending", 64'(q8.size() > 0), 64'd1);
      if (q8.size() > 0) begin
        mon8_e = q8.pop_front();
        chk("hi8", 64'(bus8.hi_o), 64'(mon8_e.hi[7:0]));
        chk("lo8", 64'(bus8.lo_o), 64'(mon8_e.lo[7:0]));
      end
    end
  end

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    n_chk = 0; n_pass = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    rst = 1'b1;
    bus32.start = 1'b0; bus32.op = 3'b000; bus32.src_a = 32'd0; bus32.src_b = 32'd0;
    bus32.annul = 1'b0; bus32.hi_we = 1'b0; bus32.hi_wdata = 32'd0;
    bus32.lo_we = 1'b0; bus32.lo_wdata = 32'd0;
    bus8.start = 1'b0; bus8.op = 3'b000; bus8.src_a = 8'd0; bus8.src_b = 8'd0;
    bus8.annul = 1'b0; bus8.hi_we = 1'b0; bus8.hi_wdata = 8'd0;
    bus8.lo_we = 1'b0; bus8.lo_wdata = 8'd0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_hi", 64'(bus32.hi_o), 64'd0);
    chk("rst_lo", 64'(bus32.lo_o), 64'd0);
    chk("rst_busy", 64'(bus32.busy), 64'd0);
    chk("rst_done", 64'(bus32.done), 64'd0);
    chk("rst_dz", 64'(bus32.div_zero), 64'd0);
    chk("rst_hi8", 64'(bus8.hi_o), 64'd0);

    // Directed cases with hand-derived results.
    exp_raw32(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    do_op32(3'b000, 32'hFFFF_FFFD, 32'd5, 34, "mult", -1, 32'd0, 32'd0, nb, ns);
    chk("mult_busy_cycles", 64'(nb), 64'd33);
    chk("mult_stall_cycles", 64'(ns), 64'd34);
    tick();
    exp_raw32(32'd2, 32'd14, 1'b0);
    do_op32(3'b011, 32'd100, 32'd7, 34, "divu", -1, 32'd0, 32'd0, nb, ns);
    exp_raw32(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op32(3'b010, 32'hFFFF_FFF9, 32'd2, 34, "div", -1, 32'd0, 32'd0, nb, ns);
    exp_raw32(32'd0, 32'h8000_0000, 1'b0);
    do_op32(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 34, "div_ovf", -1, 32'd0, 32'd0, nb, ns);
    exp_raw32(32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    do_op32(3'b010, 32'h0000_1234, 32'd0, 2, "div0", -1, 32'd0, 32'd0, nb, ns);
    tick();
    mt32(32'd0, 32'hFFFF_FFFF);
    exp_raw32(32'd1, 32'd0, 1'b0);
    do_op32(3'b101, 32'd1, 32'd1, 34, "maddu", -1, 32'd0, 32'd0, nb, ns);
    tick();
    mt32(32'd0, 32'd0);
    exp_raw32(32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    do_op32(3'b110, 32'd2, 32'd3, 34, "msub", -1, 32'd0, 32'd0, nb, ns);
    tick();
    // MTHI/MTLO in CALC feeds the accumulate; one on the commit edge loses to the commit.
    exp_raw32(32'd5, 32'd6, 1'b0);
    do_op32(3'b101, 32'd2, 32'd3, 34, "madd_wr", 5, 32'd5, 32'd0, nb, ns);
    tick();
    exp_raw32(32'd0, 32'd4, 1'b0);
    do_op32(3'b001, 32'd2, 32'd2, 34, "commit_wins", 33, 32'hDEAD, 32'hBEEF, nb, ns);
    tick();

    // start together with annul in IDLE is suppressed.
    bus32.op = 3'b001; bus32.src_a = 32'd3; bus32.src_b = 32'd3;
    bus32.start = 1'b1; bus32.annul = 1'b1;
    #1;
    chk("annul_start_stall", 64'(bus32.stallreq), 64'd0);
    tick();
    bus32.start = 1'b0; bus32.annul = 1'b0;
    #1;
    chk("annul_start_busy", 64'(bus32.busy), 64'd0);

    // Annul mid-operation, then a fresh start in cycle 12.
    bus32.op = 3'b001; bus32.src_a = 32'd7; bus32.src_b = 32'd9; bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
    repeat (9) tick();
    bus32.annul = 1'b1;
    tick();
    bus32.annul = 1'b0;
    #1;
    chk("annul_busy", 64'(bus32.busy), 64'd0);
    chk("annul_hi", 64'(bus32.hi_o), 64'(m_hi));
    chk("annul_lo", 64'(bus32.lo_o), 64'(m_lo));
    tick();
    exp32(3'b001, 32'd7, 32'd9);
    do_op32(3'b001, 32'd7, 32'd9, 34, "after_annul", -1, 32'd0, 32'd0, nb, ns);
    tick();

    // Reset mid-operation.
    bus32.op = 3'b001; bus32.src_a = 32'd7; bus32.src_b = 32'd9; bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(bus32.busy), 64'd0);
    chk("rst_mid_hi", 64'(bus32.hi_o), 64'd0);
    chk("rst_mid_lo", 64'(bus32.lo_o), 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    tick();

    // Random back-to-back ops against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 50));
      if ($urandom_range(0, 5) == 0) begin
        r_b = 32'd0;
      end else begin
        r_b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 20));
      end
      exp32(r_op, r_a, r_b);
      do_op32(r_op, r_a, r_b, ((r_op[2:1] == 2'b01) && (r_b == 32'd0)) ? 2 : 34,
              "rand", -1, 32'd0, 32'd0, nb, ns);
    end
    tick();

    // 8-bit instance without accumulate ops.
    exp_raw8(32'hFF, 32'hFE);
    do_op8(3'b100, 8'hFF, 8'h02, 10, "madd_as_mult8", -1);
    tick();
    exp_raw8(32'hFF, 32'hFA);
    do_op8(3'b110, 8'h03, 8'hFE, 10, "msub_as_mult8", -1);
    tick();
    exp_raw8(32'h00, 32'h0C);
    do_op8(3'b001, 8'd3, 8'd4, 10, "ign_start8", 4);
    repeat (15) tick();
    chk("ign_start8_idle", 64'(bus8.busy), 64'd0);

    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
